// File: rtl/li_pkg.sv
// Shared width helpers for the latency-insensitive credit blocks.
// Counters span 0..Depth inclusive; pointers span 0..Depth-1.
package li_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/li_credit_mem.sv
// Depth x Width token storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module li_credit_mem
    import li_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(Depth)-1:0]   waddr,
    input  logic [Width-1:0]          wdata,
    input  logic [ptr_w(Depth)-1:0]   raddr,
    output logic [Width-1:0]          rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/li_credit_receiver.sv
// Receive end of a credit-flow-controlled link: buffers pushed tokens, drains them onto a
// valid/bp output and returns one credit per drained token. Optional LI_CREDIT_BYPASS_EN.
module li_credit_receiver
    import li_pkg::*;
#(
    parameter string Name  = "",
    parameter int    Width = 8,
    parameter int    Depth = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [Width-1:0]         d,
    input  logic                     d_valid,
    output logic [Width-1:0]         q,
    output logic                     q_valid,
    input  logic                     q_bp,
    output logic                     credit_return,
    output logic [cnt_w(Depth)-1:0]  count,
    output logic                     overflow
);

    localparam int CntW = cnt_w(Depth);
    localparam int PtrW = ptr_w(Depth);

    typedef logic [CntW-1:0] li_cnt_t;
    typedef logic [PtrW-1:0] li_ptr_t;

    // Elaboration-time trace hook; the label identifies the instance in simulation logs.
    if (Width < 1 || Depth < 2) begin : g_bad_cfg
        $error("li_credit_receiver %s: needs Width>=1 and Depth>=2", Name);
    end else begin : g_cfg_info
        $info("li_credit_receiver %s: Width=%0d Depth=%0d", Name, Width, Depth);
    end

    li_ptr_t          rd_ptr_reg;
    li_ptr_t          wr_ptr_reg;
    li_cnt_t          count_reg;
    li_cnt_t          count_next;
    logic             credit_reg;
    logic             overflow_reg;
    logic [Width-1:0] rdata;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             outgoing;
    logic             push;
    logic             pop;
    logic             drop;

    function automatic li_ptr_t ptr_inc(input li_ptr_t p);
        return (p == li_ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_reg == '0);
    assign full  = (count_reg == li_cnt_t'(Depth));

`ifdef LI_CREDIT_BYPASS_EN
    assign bypass = empty & d_valid;
`else
    assign bypass = 1'b0;
`endif

    assign q_valid  = ~empty | bypass;
    assign q        = bypass ? d : rdata;
    assign outgoing = q_valid & ~q_bp;

    // A bypassed token that leaves immediately never touches storage.
    assign pop  = outgoing & ~empty;
    assign push = d_valid & ~(bypass & ~q_bp) & (~full | pop);
    assign drop = d_valid & full & ~pop;

    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            credit_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg  <= count_next;
            credit_reg <= outgoing;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    li_credit_mem #(
        .Width (Width),
        .Depth (Depth)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (d),
        .raddr (rd_ptr_reg),
        .rdata (rdata)
    );

    assign count         = count_reg;
    assign credit_return = credit_reg;
    assign overflow      = overflow_reg;

endmodule
